// File: rtl/mul4_if.sv
// mul4_if: operand/result handshake bundle for the mul4 sequencing controller
//   in_valid/in_ready + a1,a0,b1,b0 : operand channel (source -> controller)
//   flush                          : synchronous abort from the source side
//   out_valid/out_ready + y3..y0   : product channel (controller -> consumer)
//   busy, op_count                 : status (controller -> observers)
//   modport master : source/consumer side; modport slave : controller side
interface mul4_if #(parameter int W = 16, parameter int CNT_W = 16);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a1, a0, b1, b0;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     y3, y2, y1, y0;
  logic             busy;
  logic [CNT_W-1:0] op_count;
  modport master (output in_valid, a1, a0, b1, b0, flush, out_ready,
                  input  in_ready, out_valid, y3, y2, y1, y0, busy, op_count);
  modport slave  (input  in_valid, a1, a0, b1, b0, flush, out_ready,
                  output in_ready, out_valid, y3, y2, y1, y0, busy, op_count);
endinterface

// File: rtl/mul4_seq_ctrl.sv
// mul4_seq_ctrl: 4W-bit product of {a1,a0}*{b1,b0} using one WxW multiplier over four steps
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : mul4_if.slave -- operand handshake, flush, product handshake, busy, op_count
module mul4_seq_ctrl #(
  parameter int W     = 16,
  parameter int CNT_W = 16
) (
  input  logic   clk,
  input  logic   rst_n,
  mul4_if.slave  bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]       state;
  logic [1:0]       step;
  logic [4*W-1:0]   acc, y, term, sum;
  logic [W-1:0]     la1, la0, lb1, lb0, xa, xb;
  logic [2*W-1:0]   pp;
  logic             out_valid;
  logic [CNT_W-1:0] op_count;
  // step 0: a0*b0, 1: a0*b1, 2: a1*b0, 3: a1*b1
  always_comb begin
    xa   = step[1] ? la1 : la0;
    xb   = step[0] ? lb1 : lb0;
    pp   = {{W{1'b0}}, xa} * {{W{1'b0}}, xb};
    term = step == 2'd0 ? {{2*W{1'b0}}, pp}
         : step == 2'd3 ? {pp, {2*W{1'b0}}}
         :                {{W{1'b0}}, pp, {W{1'b0}}};
    sum  = acc + term;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      step      <= 2'd0;
      acc       <= '0;
      y         <= '0;
      out_valid <= 1'b0;
      op_count  <= '0;
      la1       <= '0;
      la0       <= '0;
      lb1       <= '0;
      lb0       <= '0;
    end else if (bus.flush) begin
      state     <= IDLE;
      step      <= 2'd0;
      out_valid <= 1'b0;
    end else if (state == IDLE) begin
      if (bus.in_valid) begin
        la1   <= bus.a1;
        la0   <= bus.a0;
        lb1   <= bus.b1;
        lb0   <= bus.b0;
        acc   <= '0;
        step  <= 2'd0;
        state <= MUL;
      end
    end else if (state == MUL) begin
      acc  <= sum;
      step <= step + 2'd1;
      if (step == 2'd3) begin
        y         <= sum;
        out_valid <= 1'b1;
        state     <= DONE;
      end
    end else if (bus.out_ready) begin
      out_valid <= 1'b0;
      op_count  <= op_count + CNT_W'(1);
      state     <= IDLE;
    end
  end
  assign bus.in_ready  = state == IDLE;
  assign bus.busy      = state != IDLE;
  assign bus.out_valid = out_valid;
  assign bus.op_count  = op_count;
  assign {bus.y3, bus.y2, bus.y1, bus.y0} = y;
endmodule
